nn_dense_layer: RTL and testbench

Fully connected layer stage of the fixed-point neural network pipeline. It sits between the input channel memory, which is filled serially by the network top, and the next layer. Once started, it reads the layer's input vector one element per access and computes each neuron with a single time-shared multiply-accumulate. It applies bias, arithmetic shift, ReLU and saturation, holds the results in output registers, and raises a sticky `ack_layer` that starts the downstream layer.

---
 rtl/nn_pkg.sv | 27 ++
 rtl/nn_dense_layer_if.sv | 40 ++++
 rtl/nn_mac_sat.sv | 33 +++
 rtl/nn_dense_layer.sv | 149 ++++++++++++++
 tb/tb_nn_dense_layer.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared constants for the fixed-point network: layer weights/biases,
// data format defaults and the dense-layer FSM state encoding.
package nn_pkg;

  localparam int W_DEFAULT    = 8;
  localparam int FRAC_DEFAULT = 4;

  // Layer 0 coefficients, Q(W-FRAC).FRAC, indexed [neuron][input] and [neuron].
  localparam int L0_N_IN  = 2;
  localparam int L0_N_OUT = 2;
  localparam int L0_WEIGHT [L0_N_OUT][L0_N_IN] = '{'{16, 16}, '{32, -16}};
  localparam int L0_BIAS   [L0_N_OUT]          = '{0, 0};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MAC  = 3'd2,
    ST_ACT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_dense_layer_if.sv
// Bundle between a dense layer, its input channel memory and the next layer.
interface nn_dense_layer_if
  import nn_pkg::*;
#(
  parameter int N_IN  = L0_N_IN,
  parameter int N_OUT = L0_N_OUT,
  parameter int W     = W_DEFAULT
);

  localparam int IW = clog2_min1(N_IN);

  // req is a level start (held until the layer is reset); in_rd is a one-cycle
  // strobe with in_addr, and in_data answers it exactly one cycle later with no
  // backpressure; ack_layer is sticky and qualifies out_data for downstream.
  logic                   req;
  logic                   in_rd;
  logic [IW-1:0]          in_addr;
  logic signed [W-1:0]    in_data;
  logic [N_OUT*W-1:0]     out_data;
  logic                   ack_layer;

  modport master (
    input  req,
    input  in_data,
    output in_rd,
    output in_addr,
    output out_data,
    output ack_layer
  );

  modport slave (
    output req,
    output in_data,
    input  in_rd,
    input  in_addr,
    input  out_data,
    input  ack_layer
  );

endinterface

// File: rtl/nn_mac_sat.sv
// Combinational datapath: accumulate one signed product, and turn an
// accumulator into a ReLU'd, saturated W-bit activation.
module nn_mac_sat #(
  parameter int W  = 8,
  parameter int AW = 18,
  parameter int SW = 5
) (
  input  logic signed [AW-1:0]  acc,
  input  logic signed [2*W-1:0] prod,
  input  logic [SW-1:0]         shift,
  output logic signed [AW-1:0]  acc_next,
  output logic [W-1:0]          res
);

  localparam logic signed [AW-1:0] MAX_POS = AW'((1 << (W-1)) - 1);

  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] shifted;

  always_comb begin
    prod_ext = {{(AW-2*W){prod[2*W-1]}}, prod};
    acc_next = acc + prod_ext;
    shifted  = acc >>> shift;
    if (shifted[AW-1]) begin
      res = '0;
    end else if (shifted > MAX_POS) begin
      res = MAX_POS[W-1:0];
    end else begin
      res = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/nn_dense_layer.sv
// Fully connected layer: one time-shared MAC walks every neuron over the
// input vector, then bias/shift/ReLU/saturate into sticky output registers.
module nn_dense_layer
  import nn_pkg::*;
#(
  parameter int N_IN  = L0_N_IN,
  parameter int N_OUT = L0_N_OUT,
  parameter int W     = W_DEFAULT,
  parameter int FRAC  = FRAC_DEFAULT,
  parameter int WEIGHT [N_OUT][N_IN] = L0_WEIGHT,
  parameter int BIAS   [N_OUT]       = L0_BIAS
) (
  input  logic             clk,
  input  logic             rst,
  nn_dense_layer_if.master bus,
  output state_e           dbg_state
);

  localparam int IW = clog2_min1(N_IN);
  localparam int KW = clog2_min1(N_OUT);
  // Wide enough for N_IN full-scale products plus a shifted bias.
  localparam int AW = 2*W + $clog2(N_IN) + 1;
  localparam int SW = $clog2(AW + 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         i_q, i_d;
  logic [KW-1:0]         k_q, k_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic                  in_rd_q, in_rd_d;
  logic [IW-1:0]         in_addr_q, in_addr_d;
  logic [N_OUT*W-1:0]    out_q, out_d;
  logic                  ack_q, ack_d;

  logic signed [W-1:0]   w_cur;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  acc_next;
  logic [W-1:0]          res;

  function automatic logic signed [AW-1:0] bias_to_acc(input logic [KW-1:0] idx);
    logic signed [W-1:0] b;
    b = W'(BIAS[idx]);
    return {{(AW-W){b[W-1]}}, b} <<< FRAC;
  endfunction

  always_comb begin
    w_cur = W'(WEIGHT[k_q][i_q]);
    prod  = (2*W)'(w_cur) * (2*W)'(bus.in_data);
  end

  nn_mac_sat #(
    .W  (W),
    .AW (AW),
    .SW (SW)
  ) u_mac_sat (
    .acc      (acc_q),
    .prod     (prod),
    .shift    (SW'(FRAC)),
    .acc_next (acc_next),
    .res      (res)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    k_d       = k_q;
    acc_d     = acc_q;
    out_d     = out_q;
    ack_d     = ack_q;
    in_rd_d   = 1'b0;
    in_addr_d = in_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          i_d     = '0;
          k_d     = '0;
          acc_d   = bias_to_acc('0);
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d = acc_next;
        if (i_q == IW'(N_IN-1)) begin
          state_d = ST_ACT;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = ST_RD;
        end
      end
      ST_ACT: begin
        for (int s = 0; s < N_OUT; s++) begin
          if (KW'(s) == k_q) out_d[s*W +: W] = res;
        end
        if (k_q == KW'(N_OUT-1)) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + KW'(1);
          i_d     = '0;
          acc_d   = bias_to_acc(k_q + KW'(1));
          state_d = ST_RD;
        end
      end
      ST_DONE: begin
        ack_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobe and address are registered so they line up with the RD cycle.
    if (state_d == ST_RD) begin
      in_rd_d   = 1'b1;
      in_addr_d = i_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      in_rd_q   <= 1'b0;
      in_addr_q <= '0;
      out_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      in_rd_q   <= in_rd_d;
      in_addr_q <= in_addr_d;
      out_q     <= out_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.in_rd     = in_rd_q;
  assign bus.in_addr   = in_addr_q;
  assign bus.out_data  = out_q;
  assign bus.ack_layer = ack_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_nn_dense_layer.sv
// Directed bench for nn_dense_layer with default parameters and the layer-0
// coefficients {{16,16},{32,-16}}, bias {0,0}.
module tb_nn_dense_layer;
  import nn_pkg::*;

  localparam int W = 8;
  localparam logic signed [W-1:0] GARBAGE = 8'sh5A;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  nn_dense_layer_if #(.N_IN(2), .N_OUT(2), .W(W)) bus ();

  nn_dense_layer #(
    .N_IN  (2),
    .N_OUT (2),
    .W     (W),
    .FRAC  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  logic signed [W-1:0] x_mem [2];
  int rd_edges [$];
  int rd_addrs [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int s);
    return 32'(bus.out_data[s*W +: W]);
  endfunction

  // One clock edge; acts as the input memory, answering a strobe seen at this
  // edge with data during the following cycle only.
  task automatic tick();
    logic rd;
    logic addr;
    rd   = bus.in_rd;
    addr = bus.in_addr;
    @(posedge clk);
    edge_cnt++;
    #1;
    if (rd === 1'b1) begin
      rd_edges.push_back(edge_cnt);
      rd_addrs.push_back(int'(addr));
      bus.in_data = x_mem[addr];
    end else begin
      bus.in_data = GARBAGE;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    check({tag, "_out"}, bus.out_data, 32'd0);
    check({tag, "_ack"}, bus.ack_layer, 32'd0);
    check({tag, "_in_rd"}, bus.in_rd, 32'd0);
    check({tag, "_in_addr"}, bus.in_addr, 32'd0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // Edge 0 is the first edge after this task releases rst with req high.
  task automatic run(input string tag, input logic signed [W-1:0] x0,
                     input logic signed [W-1:0] x1, input int exp0, input int exp1);
    int ack_edge;
    int exp_edges [4];
    int exp_addrs [4];
    exp_edges = '{1, 3, 6, 8};
    exp_addrs = '{0, 1, 0, 1};
    x_mem[0] = x0;
    x_mem[1] = x1;
    rd_edges.delete();
    rd_addrs.delete();
    edge_cnt = -1;
    ack_edge = -1;
    rst      = 1'b0;
    bus.req  = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (edge_cnt == 4) check({tag, "_slot0_before_act"}, slot(0), 32'd0);
      if (edge_cnt == 5) begin
        check({tag, "_slot0_at_edge5"}, slot(0), 32'(exp0));
        check({tag, "_slot1_at_edge5"}, slot(1), 32'd0);
      end
      if (bus.ack_layer === 1'b1 && ack_edge < 0) ack_edge = edge_cnt;
    end
    check({tag, "_ack_edge"}, 32'(ack_edge), 32'd11);
    check({tag, "_slot0"}, slot(0), 32'(exp0));
    check({tag, "_slot1"}, slot(1), 32'(exp1));
    check({tag, "_rd_count"}, 32'(rd_edges.size()), 32'd4);
    if (rd_edges.size() == 4) begin
      for (int j = 0; j < 4; j++) begin
        check($sformatf("%s_rd%0d_edge", tag, j), 32'(rd_edges[j]), 32'(exp_edges[j]));
        check($sformatf("%s_rd%0d_addr", tag, j), 32'(rd_addrs[j]), 32'(exp_addrs[j]));
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = 1'b0;
    bus.in_data = GARBAGE;
    x_mem[0]    = '0;
    x_mem[1]    = '0;

    do_reset("reset");

    // req low: nothing happens
    rst = 1'b0;
    rd_edges.delete();
    for (int e = 0; e < 4; e++) tick();
    check("idle_no_rd", 32'(rd_edges.size()), 32'd0);
    check("idle_ack", bus.ack_layer, 32'd0);
    check("idle_state", dbg_state, ST_IDLE);

    // 16*16+16*32=768>>4=48 ; 32*16-16*32=0
    run("basic", 8'sd16, 8'sd32, 48, 0);

    // req held high after DONE: no new reads, results frozen, ack sticky
    rd_edges.delete();
    for (int e = 0; e < 8; e++) tick();
    check("sticky_no_rd", 32'(rd_edges.size()), 32'd0);
    check("sticky_ack", bus.ack_layer, 32'd1);
    check("sticky_slot0", slot(0), 32'd48);
    check("sticky_slot1", slot(1), 32'd0);
    check("sticky_state", dbg_state, ST_DONE);

    // 16*16=256>>4=16 ; -16*16=-256>>4=-16 -> ReLU 0
    do_reset("rst_relu");
    run("relu", 8'sd0, 8'sd16, 16, 0);

    // 32*127=4064>>4=254 -> 127 ; 16*127=2032>>4=127
    do_reset("rst_sat");
    run("sat", 8'sd127, 8'sd127, 127, 127);

    // rst sampled at edge 5, just as slot0 would have been written
    do_reset("rst_mid");
    x_mem[0] = 8'sd16;
    x_mem[1] = 8'sd32;
    edge_cnt = -1;
    rst      = 1'b0;
    bus.req  = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_out", bus.out_data, 32'd0);
    check("mid_rst_ack", bus.ack_layer, 32'd0);
    check("mid_rst_in_rd", bus.in_rd, 32'd0);
    check("mid_rst_in_addr", bus.in_addr, 32'd0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    run("restart", 8'sd16, 8'sd32, 48, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
